hex_display_driver: RTL and testbench

//   Downstream consumer of the processor's 16-bit debug result bus. Latches the

---
 rtl/hex_display_driver.sv | 132 +++++++++++++
 tb/tb_hex_display_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_driver.sv
// Four-digit time-multiplexed hex display for a 16-bit debug bus, with per-slot PWM and leading-zero blanking.
// Latency: display outputs are registered one cycle after idx/phase/disp; loads take effect at the next frame boundary.
// Backpressure: none; load is a fire-and-forget strobe and the last load before a boundary wins.
module hex_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] result_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [2:0]  brightness,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n
);
    localparam int PHASE_LEN = REFRESH_DIV / 8;
    localparam int CW        = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [CW-1:0] PC_MAX = CW'(PHASE_LEN - 1);

    logic [CW-1:0] r_phase_cnt;
    logic [2:0]    r_phase;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [15:0]   r_disp;
    logic          r_pending;
    logic          r_heartbeat;

    logic          w_pc_wrap;
    logic          w_ph_wrap;
    logic          w_boundary;
    logic [3:0]    w_nibble;
    logic [6:0]    w_glyph;
    logic          w_blank;
    logic          w_lit;
    logic [3:0]    w_an;

    assign w_pc_wrap  = (r_phase_cnt == PC_MAX);
    assign w_ph_wrap  = w_pc_wrap && (r_phase == 3'd7);
    assign w_boundary = w_ph_wrap && (r_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_cnt <= '0;
            r_phase     <= 3'd0;
            r_idx       <= 2'd0;
        end else begin
            r_phase_cnt <= w_pc_wrap ? '0 : r_phase_cnt + 1'b1;
            if (w_pc_wrap)
                r_phase <= r_phase + 3'd1;
            if (w_ph_wrap)
                r_idx <= r_idx + 2'd1;
        end
    end

    // disp only changes at the frame boundary so a frame never mixes two values;
    // a load landing on the boundary itself bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= 16'h0000;
            r_disp      <= 16'h0000;
            r_pending   <= 1'b0;
            r_heartbeat <= 1'b0;
        end else begin
            if (load)
                r_shadow <= result_in;
            if (w_boundary) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_disp      <= result_in;
                    r_heartbeat <= ~r_heartbeat;
                end else if (r_pending) begin
                    r_disp      <= r_shadow;
                    r_heartbeat <= ~r_heartbeat;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_glyph = 7'h7F;
        case (w_nibble)
            4'h0: w_glyph = 7'b1000000;
            4'h1: w_glyph = 7'b1111001;
            4'h2: w_glyph = 7'b0100100;
            4'h3: w_glyph = 7'b0110000;
            4'h4: w_glyph = 7'b0011001;
            4'h5: w_glyph = 7'b0010010;
            4'h6: w_glyph = 7'b0000010;
            4'h7: w_glyph = 7'b1111000;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0010000;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b0000011;
            4'hC: w_glyph = 7'b1000110;
            4'hD: w_glyph = 7'b0100001;
            4'hE: w_glyph = 7'b0000110;
            4'hF: w_glyph = 7'b0001110;
            default: w_glyph = 7'h7F;
        endcase
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = blank_lz && (r_disp[15:4]  == 12'h000);
            2'd2:    w_blank = blank_lz && (r_disp[15:8]  == 8'h00);
            2'd3:    w_blank = blank_lz && (r_disp[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end

    assign w_lit = !w_blank && (r_phase <= brightness);
    assign w_an  = w_lit ? ~(4'b0001 << r_idx) : 4'hF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 4'hF;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= w_an;
            seg_n <= w_glyph;
            dp_n  <= !((r_idx == 2'd0) && w_lit && r_heartbeat);
        end
    end
endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver with REFRESH_DIV=16 (16-cycle slots, 64-cycle frames).
// Expected outputs are queued as stimulus is driven and compared when the display reaches that point.
// k counts clock edges since reset release; outputs after edge k reflect timing state k-1.
module tb_hex_display_driver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] result_in;
    logic        load;
    logic        blank_lz;
    logic [2:0]  brightness;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;
    int    k     = 0;
    int    cnt;
    int    lead;
    int    multi = 0;

    hex_display_driver #(.REFRESH_DIV(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .result_in  (result_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        if ($countones(~an_n) > 1) multi++;
    endtask

    task automatic run_to(input int t);
        while (k < t) tick();
    endtask

    task automatic push(input string t, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        exp_t e;
        e.an  = an;
        e.seg = seg;
        e.dp  = dp;
        sb_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic pop_chk();
        exp_t  e;
        exp_t  obs;
        string t;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: got no entry required one");
        end else begin
            e   = sb_q.pop_front();
            t   = tag_q.pop_front();
            obs = {an_n, seg_n, dp_n};
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: an_n/seg_n/dp_n got %b/%b/%b required %b/%b/%b",
                       t, obs.an, obs.seg, obs.dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic chk_int(input string t, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d required %0d", t, got, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        load       = 1'b0;
        result_in  = 16'h0000;
        blank_lz   = 1'b0;
        brightness = 3'd7;
        #1 rst_n = 1'b0;

        // 1. reset and release
        repeat (2) @(posedge clk);
        #1;
        push("reset_early", 4'hF, 7'h7F, 1'b1);
        pop_chk();
        repeat (3) @(posedge clk);
        #1;
        push("reset_hold", 4'hF, 7'h7F, 1'b1);
        pop_chk();
        rst_n = 1'b1;
        k     = 0;
        multi = 0;
        push("release", 4'b1110, 7'b1000000, 1'b1);
        tick();
        pop_chk();

        // 2. mid-frame load is held until the boundary
        run_to(20);
        result_in = 16'h1234;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        result_in = 16'h0000;
        push("pre_boundary_d3", 4'b0111, 7'b1000000, 1'b1);
        run_to(64);
        pop_chk();
        push("frame1_d0", 4'b1110, 7'b0011001, 1'b0);
        run_to(65);
        pop_chk();
        push("frame1_d3", 4'b0111, 7'b1111001, 1'b1);
        run_to(113);
        pop_chk();

        // 3. leading-zero blanking
        run_to(120);
        blank_lz  = 1'b1;
        result_in = 16'h0005;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        result_in = 16'h0000;
        push("blank_d0_five", 4'b1110, 7'b0010010, 1'b1);
        run_to(129);
        pop_chk();
        lead = 0;
        while (k < 192) begin
            tick();
            if (an_n[3:1] != 3'b111) lead++;
            load = (k == 150);
            if (k == 145) begin
                push("blank_d1", 4'hF, 7'b1000000, 1'b1);
                pop_chk();
            end
        end
        load = 1'b0;
        chk_int("blank_lead_anodes_low", lead, 0);
        push("zero_d0", 4'b1110, 7'b1000000, 1'b0);
        run_to(193);
        pop_chk();

        // 4. PWM duty per slot
        blank_lz   = 1'b0;
        brightness = 3'd0;
        cnt = 0;
        while (k < 224) begin
            tick();
            if (!an_n[1]) cnt++;
        end
        chk_int("bright0_slot_low_cycles", cnt, 2);
        brightness = 3'd7;
        cnt = 0;
        while (k < 240) begin
            tick();
            if (!an_n[2]) cnt++;
        end
        chk_int("bright7_slot_low_cycles", cnt, 16);
        brightness = 3'd3;
        cnt = 0;
        while (k < 256) begin
            tick();
            if (!an_n[3]) cnt++;
        end
        chk_int("bright3_slot_low_cycles", cnt, 8);
        brightness = 3'd7;

        // 5. load on the boundary cycle beats a pending shadow value
        push("hb_before", 4'b1110, 7'b1000000, 1'b0);
        run_to(257);
        pop_chk();
        run_to(260);
        result_in = 16'h1111;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        run_to(319);
        result_in = 16'hABCD;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        result_in = 16'h0000;
        push("abcd_d0", 4'b1110, 7'b0100001, 1'b1);
        run_to(321);
        pop_chk();
        push("abcd_d3", 4'b0111, 7'b0001000, 1'b1);
        run_to(369);
        pop_chk();
        push("no_second_toggle", 4'b1110, 7'b0100001, 1'b1);
        run_to(385);
        pop_chk();
        chk_int("one_anode_max", multi, 0);

        // 6. asynchronous reset in the middle of slot 2
        run_to(420);
        #2;
        rst_n = 1'b0;
        #1;
        push("async_reset", 4'hF, 7'h7F, 1'b1);
        pop_chk();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k     = 0;
        push("post_reset_d0", 4'b1110, 7'b1000000, 1'b1);
        tick();
        pop_chk();
        push("post_reset_d1", 4'b1101, 7'b1000000, 1'b1);
        run_to(17);
        pop_chk();
        chk_int("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
